// File: rtl/program_loader.sv
// Byte-stream program loader: length header, little-endian words, one memory write per word.
// Optional trailing checksum byte when LOADER_CHECKSUM_EN is defined.
module program_loader #(
  parameter int                    MEMORY_DEPTH = 32,
  parameter int                    DATA_WIDTH   = 32,
  parameter logic [DATA_WIDTH-1:0] BASE_ADDRESS = 'h0040_0000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start_i,
  input  logic [7:0]            byte_i,
  input  logic                  byte_valid_i,
  output logic                  byte_ready_o,
  output logic                  mem_we_o,
  output logic [DATA_WIDTH-1:0] mem_address_o,
  output logic [DATA_WIDTH-1:0] mem_data_o,
  output logic                  cpu_hold_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  error_o,
  output logic [15:0]           words_loaded_o,
  output logic [2:0]            state_o
);

  // Handshake: a byte moves on a rising edge where byte_valid_i && byte_ready_o;
  // the source holds byte_i stable until then, ready never depends on valid.

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LEN_LO = 3'd1,
    S_LEN_HI = 3'd2,
    S_DATA   = 3'd3,
    S_WRITE  = 3'd4,
`ifdef LOADER_CHECKSUM_EN
    S_CHECK  = 3'd5,
`endif
    S_DONE   = 3'd6,
    S_ERROR  = 3'd7
  } state_t;

  localparam logic [15:0] DEPTH16 = 16'(MEMORY_DEPTH);

  state_t                state_q, state_d;
  logic [15:0]           count_q;
  logic [1:0]            byte_idx_q;
  logic [23:0]           asm_q;
  logic [15:0]           words_q;
  logic [DATA_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic                  xfer;
  logic                  start_ok;
  logic [15:0]           len_d;
  logic                  last_word;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]            sum_q;
`endif

  assign xfer      = byte_valid_i && byte_ready_o;
  assign start_ok  = start_i && (state_q == S_IDLE || state_q == S_DONE || state_q == S_ERROR);
  assign len_d     = {byte_i, count_q[7:0]};
  assign last_word = (16'(words_q + 16'd1) == count_q);

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_DONE, S_ERROR: if (start_i) state_d = S_LEN_LO;
      S_LEN_LO: if (xfer) state_d = S_LEN_HI;
      S_LEN_HI: begin
        if (xfer) state_d = (len_d == 16'd0 || len_d > DEPTH16) ? S_ERROR : S_DATA;
      end
      S_DATA:   if (xfer && byte_idx_q == 2'd3) state_d = S_WRITE;
      S_WRITE: begin
        if (!last_word)
          state_d = S_DATA;
        else
`ifdef LOADER_CHECKSUM_EN
          state_d = S_CHECK;
`else
          state_d = S_DONE;
`endif
      end
`ifdef LOADER_CHECKSUM_EN
      S_CHECK:  if (xfer) state_d = (byte_i == sum_q) ? S_DONE : S_ERROR;
`endif
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    byte_ready_o = 1'b0;
    mem_we_o     = 1'b0;
    cpu_hold_o   = 1'b0;
    busy_o       = 1'b0;
    done_o       = 1'b0;
    error_o      = 1'b0;
    case (state_q)
      S_LEN_LO, S_LEN_HI, S_DATA: begin
        byte_ready_o = 1'b1;
        cpu_hold_o   = 1'b1;
        busy_o       = 1'b1;
      end
      S_WRITE: begin
        mem_we_o   = 1'b1;
        cpu_hold_o = 1'b1;
        busy_o     = 1'b1;
      end
`ifdef LOADER_CHECKSUM_EN
      S_CHECK: begin
        byte_ready_o = 1'b1;
        cpu_hold_o   = 1'b1;
        busy_o       = 1'b1;
      end
`endif
      S_DONE:  done_o = 1'b1;
      S_ERROR: begin
        error_o    = 1'b1;
        cpu_hold_o = 1'b1;
      end
      default: ;
    endcase
  end

  // The output word/address are captured as the 4th byte lands, so they stay
  // stable through WRITE and afterwards while the next word assembles.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q    <= '0;
      byte_idx_q <= '0;
      asm_q      <= '0;
      words_q    <= '0;
      addr_q     <= BASE_ADDRESS;
      data_q     <= '0;
`ifdef LOADER_CHECKSUM_EN
      sum_q      <= '0;
`endif
    end else if (start_ok) begin
      words_q    <= '0;
      byte_idx_q <= '0;
`ifdef LOADER_CHECKSUM_EN
      sum_q      <= '0;
`endif
    end else begin
      case (state_q)
        S_LEN_LO: if (xfer) count_q[7:0]  <= byte_i;
        S_LEN_HI: if (xfer) count_q[15:8] <= byte_i;
        S_DATA: begin
          if (xfer) begin
            byte_idx_q <= byte_idx_q + 2'd1;
`ifdef LOADER_CHECKSUM_EN
            sum_q      <= sum_q + byte_i;
`endif
            if (byte_idx_q == 2'd3) begin
              data_q <= DATA_WIDTH'({byte_i, asm_q});
              addr_q <= BASE_ADDRESS + (DATA_WIDTH'(words_q) << 2);
            end else begin
              asm_q[{byte_idx_q, 3'b000} +: 8] <= byte_i;
            end
          end
        end
        S_WRITE: words_q <= words_q + 16'd1;
        default: ;
      endcase
    end
  end

  assign mem_address_o  = addr_q;
  assign mem_data_o     = data_q;
  assign words_loaded_o = words_q;
  assign state_o        = state_q;

endmodule

// File: tb/tb_program_loader.sv
// Self-checking bench for program_loader: randomized images against a queue of expected writes.
// Define LOADER_CHECKSUM_EN for both bench and RTL to cover the checksum build.
module tb_program_loader;
  localparam int          DEPTH = 32;
  localparam logic [31:0] BASE  = 32'h0040_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        start_i;
  logic [7:0]  byte_i;
  logic        byte_valid_i;
  logic        byte_ready_o;
  logic        mem_we_o;
  logic [31:0] mem_address_o;
  logic [31:0] mem_data_o;
  logic        cpu_hold_o;
  logic        busy_o;
  logic        done_o;
  logic        error_o;
  logic [15:0] words_loaded_o;
  logic [2:0]  state_o;

  int          errors = 0;
  int          checks = 0;
  int          wr_count = 0;
  longint      cyc = 0;
  logic [63:0] exp_q[$];
  logic [7:0]  payload[$];

  program_loader #(.MEMORY_DEPTH(DEPTH), .DATA_WIDTH(32), .BASE_ADDRESS(BASE)) dut (
    .clk(clk), .reset(reset), .start_i(start_i), .byte_i(byte_i),
    .byte_valid_i(byte_valid_i), .byte_ready_o(byte_ready_o), .mem_we_o(mem_we_o),
    .mem_address_o(mem_address_o), .mem_data_o(mem_data_o), .cpu_hold_o(cpu_hold_o),
    .busy_o(busy_o), .done_o(done_o), .error_o(error_o),
    .words_loaded_o(words_loaded_o), .state_o(state_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard: every write strobe must match the head of exp_q.
  always @(negedge clk) begin
    if (mem_we_o === 1'b1) begin
      logic [63:0] e;
      wr_count++;
      checks++;
      if (byte_ready_o !== 1'b0) begin
        errors++;
        $display("FAIL ready_in_write: got %b want 0", byte_ready_o);
      end
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write: addr %h data %h", mem_address_o, mem_data_o);
      end else begin
        e = exp_q.pop_front();
        if ({mem_address_o, mem_data_o} !== e)
        begin
          errors++;
          $display("FAIL write: got addr %h data %h want addr %h data %h",
                   mem_address_o, mem_data_o, e[63:32], e[31:0]);
        end
      end
    end
  end

  task automatic do_reset(input int n);
    reset = 1'b1; start_i = 1'b0; byte_valid_i = 1'b0; byte_i = 8'h00;
    repeat (n) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic pulse_start();
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit stall);
    int n;
    if (stall) begin
      byte_valid_i = 1'b0;
      @(negedge clk);
    end
    byte_i = b;
    byte_valid_i = 1'b1;
    n = 0;
    while (byte_ready_o !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 200) begin
      errors++;
      $display("FAIL byte_accept: ready stayed %b want 1", byte_ready_o);
    end else begin
      @(negedge clk);
    end
  endtask

  // Expected image: word i lands at BASE + 4*i, bytes sent least significant first.
  task automatic build_image(input int n);
    logic [31:0] w;
    payload.delete();
    for (int i = 0; i < n; i++) begin
      w = $urandom;
      exp_q.push_back({BASE + 32'(4 * i), w});
      for (int k = 0; k < 4; k++) payload.push_back(w[8*k +: 8]);
    end
  endtask

  function automatic logic [7:0] payload_sum();
    logic [7:0] s = 8'h00;
    foreach (payload[i]) s = s + payload[i];
    return s;
  endfunction

  function automatic bit pick_stall(input int mode);
    if (mode == 1) return 1'b1;
    if (mode == 2) return 1'($urandom_range(0, 1));
    return 1'b0;
  endfunction

  task automatic send_header(input logic [15:0] n, input int mode);
    send_byte(n[7:0], pick_stall(mode));
    send_byte(n[15:8], pick_stall(mode));
  endtask

  task automatic send_payload(input int first, input int last, input int mode);
    for (int i = first; i < last; i++) send_byte(payload[i], pick_stall(mode));
  endtask

  task automatic send_tail(input logic [7:0] ck, input int mode);
`ifdef LOADER_CHECKSUM_EN
    send_byte(ck, pick_stall(mode));
`else
    if (ck == 8'h00 && mode < 0) send_byte(ck, 1'b0);
`endif
    byte_valid_i = 1'b0;
  endtask

  task automatic wait_end();
    int n = 0;
    while (done_o !== 1'b1 && error_o !== 1'b1 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 2000) begin
      errors++;
      $display("FAIL session_end: done %b error %b after %0d cycles", done_o, error_o, n);
    end
  endtask

  task automatic run_load(input int n, input int mode);
    wr_count = 0;
    build_image(n);
    pulse_start();
    send_header(16'(n), mode);
    send_payload(0, payload.size(), mode);
    send_tail(payload_sum(), mode);
    wait_end();
  endtask

  task automatic test_reset();
    do_reset(2);
    checks++;
    if ({byte_ready_o, mem_we_o, cpu_hold_o, busy_o, done_o, error_o} !== 6'b0) begin
      errors++;
      $display("FAIL reset_flags: got %b want 000000",
               {byte_ready_o, mem_we_o, cpu_hold_o, busy_o, done_o, error_o});
    end
    checks++;
    if (mem_address_o !== BASE) begin
      errors++;
      $display("FAIL reset_addr: got %h want %h", mem_address_o, BASE);
    end
    checks++;
    if (mem_data_o !== 32'h0) begin
      errors++;
      $display("FAIL reset_data: got %h want 0", mem_data_o);
    end
    checks++;
    if (words_loaded_o !== 16'd0) begin
      errors++;
      $display("FAIL reset_words: got %0d want 0", words_loaded_o);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (byte_ready_o !== 1'b0) begin
      errors++;
      $display("FAIL idle_ready: got %b want 0", byte_ready_o);
    end
  endtask

  task automatic test_single_word();
    longint c0;
    int exp_len;
    wr_count = 0;
    payload.delete();
    payload.push_back(8'h13); payload.push_back(8'h05);
    payload.push_back(8'hA0); payload.push_back(8'h00);
    exp_q.push_back({32'h0040_0000, 32'h00A0_0513});
    c0 = cyc;
    pulse_start();
    checks++;
    if ({busy_o, cpu_hold_o, byte_ready_o} !== 3'b111) begin
      errors++;
      $display("FAIL len_lo_flags: got %b want 111", {busy_o, cpu_hold_o, byte_ready_o});
    end
    send_header(16'd1, 0);
    send_payload(0, 4, 0);
    send_tail(8'hB8, 0);
    wait_end();
`ifdef LOADER_CHECKSUM_EN
    exp_len = 1 + 2 + 5 + 1;
`else
    exp_len = 1 + 2 + 5;
`endif
    checks++;
    if (int'(cyc - c0) != exp_len) begin
      errors++;
      $display("FAIL session_len: got %0d want %0d", cyc - c0, exp_len);
    end
    checks++;
    if ({done_o, error_o, cpu_hold_o, busy_o} !== 4'b1000) begin
      errors++;
      $display("FAIL single_flags: got %b want 1000", {done_o, error_o, cpu_hold_o, busy_o});
    end
    checks++;
    if (words_loaded_o !== 16'd1 || wr_count != 1) begin
      errors++;
      $display("FAIL single_count: words %0d writes %0d want 1", words_loaded_o, wr_count);
    end
  endtask

  task automatic test_three_word_stall();
    run_load(3, 1);
    checks++;
    if (done_o !== 1'b1 || words_loaded_o !== 16'd3 || wr_count != 3 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL three_word: done %b words %0d writes %0d want 1/3/3",
               done_o, words_loaded_o, wr_count);
    end
  endtask

  task automatic test_bad_length();
    logic [15:0] bad[2];
    bad[0] = 16'd0;
    bad[1] = 16'(DEPTH + 1);
    for (int i = 0; i < 2; i++) begin
      wr_count = 0;
      pulse_start();
      send_header(bad[i], 0);
      byte_valid_i = 1'b0;
      wait_end();
      checks++;
      if ({error_o, done_o, cpu_hold_o, busy_o} !== 4'b1010 || wr_count != 0) begin
        errors++;
        $display("FAIL bad_len_%0d: flags %b writes %0d want 1010/0",
                 bad[i], {error_o, done_o, cpu_hold_o, busy_o}, wr_count);
      end
    end
    run_load(2, 2);
    checks++;
    if (done_o !== 1'b1 || error_o !== 1'b0 || wr_count != 2 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL recover: done %b error %b writes %0d want 1/0/2", done_o, error_o, wr_count);
    end
  endtask

  task automatic test_abort();
    wr_count = 0;
    build_image(2);
    pulse_start();
    send_header(16'd2, 0);
    send_payload(0, 6, 0);
    byte_valid_i = 1'b0;
    do_reset(1);
    checks++;
    if (cpu_hold_o !== 1'b0) begin
      errors++;
      $display("FAIL abort_hold: got %b want 0", cpu_hold_o);
    end
    repeat (4) @(negedge clk);
    checks++;
    if (wr_count != 1 || exp_q.size() != 1) begin
      errors++;
      $display("FAIL abort_writes: got %0d want 1", wr_count);
    end
    exp_q.delete();
    checks++;
    if ({byte_ready_o, mem_we_o, cpu_hold_o, busy_o, done_o, error_o} !== 6'b0 ||
        mem_address_o !== BASE || mem_data_o !== 32'h0 || words_loaded_o !== 16'd0) begin
      errors++;
      $display("FAIL abort_outputs: flags %b addr %h data %h words %0d want reset values",
               {byte_ready_o, mem_we_o, cpu_hold_o, busy_o, done_o, error_o},
               mem_address_o, mem_data_o, words_loaded_o);
    end
  endtask

  task automatic test_ignored_start();
    wr_count = 0;
    build_image(2);
    pulse_start();
    send_header(16'd2, 0);
    send_payload(0, 2, 0);
    byte_valid_i = 1'b0;
    pulse_start();
    send_payload(2, 8, 0);
    send_tail(payload_sum(), 0);
    wait_end();
    checks++;
    if (done_o !== 1'b1 || words_loaded_o !== 16'd2 || wr_count != 2 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL ignored_start: done %b words %0d writes %0d want 1/2/2",
               done_o, words_loaded_o, wr_count);
    end
  endtask

`ifdef LOADER_CHECKSUM_EN
  task automatic test_checksum();
    logic [7:0] cks[2];
    cks[0] = 8'hB8;
    cks[1] = 8'hB9;
    for (int i = 0; i < 2; i++) begin
      wr_count = 0;
      payload.delete();
      payload.push_back(8'h13); payload.push_back(8'h05);
      payload.push_back(8'hA0); payload.push_back(8'h00);
      exp_q.push_back({BASE, 32'h00A0_0513});
      pulse_start();
      send_header(16'd1, 0);
      send_payload(0, 4, 0);
      send_tail(cks[i], 0);
      wait_end();
      checks++;
      if ({done_o, error_o, cpu_hold_o} !== (i == 0 ? 3'b100 : 3'b011) || wr_count != 1) begin
        errors++;
        $display("FAIL checksum_%h: flags %b writes %0d want %b/1",
                 cks[i], {done_o, error_o, cpu_hold_o}, wr_count, (i == 0 ? 3'b100 : 3'b011));
      end
    end
  endtask
`endif

  task automatic test_max_depth();
    run_load(DEPTH, 2);
    checks++;
    if (done_o !== 1'b1 || words_loaded_o !== 16'(DEPTH) || wr_count != DEPTH || exp_q.size() != 0) begin
      errors++;
      $display("FAIL max_depth: done %b words %0d writes %0d want 1/%0d/%0d",
               done_o, words_loaded_o, wr_count, DEPTH, DEPTH);
    end
    checks++;
    if (mem_address_o !== BASE + 32'(4 * (DEPTH - 1))) begin
      errors++;
      $display("FAIL max_last_addr: got %h want %h", mem_address_o, BASE + 32'(4 * (DEPTH - 1)));
    end
  endtask

  initial begin
    start_i = 1'b0; byte_valid_i = 1'b0; byte_i = 8'h00; reset = 1'b1;
    @(negedge clk);
    test_reset();
    test_single_word();
    test_three_word_stall();
    test_bad_length();
    test_abort();
    test_ignored_start();
`ifdef LOADER_CHECKSUM_EN
    test_checksum();
`endif
    test_max_depth();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/program_loader.md
# program_loader

Writer side of the instruction store: accepts a byte stream (length header, little-endian instruction words, optional checksum) over a valid/ready handshake. It assembles 32-bit words and issues one write per word into the program memory's write port, at consecutive byte addresses starting from the text base. While a load is in progress it holds the core in reset, so the fetch path only ever reads a complete image.

## Interface
Parameters:
- MEMORY_DEPTH, 32, number of instruction words the program memory holds; largest legal word count.
- DATA_WIDTH, 32, instruction/address width.
- BASE_ADDRESS, 32'h0040_0000, byte address of word 0. The memory side drops bits [1:0] and uses bits [16:2] as the word index.

Ports (one clock; reset is synchronous and active-high, ports named clk and reset):
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high; returns the block to IDLE.
- start_i  input  1  single-cycle request to begin a load session.
- byte_i  input  8  incoming stream byte.
- byte_valid_i  input  1  byte_i holds a valid byte.
- byte_ready_o  output  1  block can accept a byte this cycle.
- mem_we_o  output  1  one-cycle write strobe to program memory.
- mem_address_o  output  DATA_WIDTH  byte address of the word being written.
- mem_data_o  output  DATA_WIDTH  assembled instruction word.
- cpu_hold_o  output  1  holds the core in reset while high.
- busy_o  output  1  session active (any state other than IDLE, DONE, ERROR).
- done_o  output  1  last session completed successfully.
- error_o  output  1  last session aborted.
- words_loaded_o  output  16  number of words written in the current or last session.

## Operation
- States:
  - IDLE
  - LEN_LO
  - LEN_HI
  - DATA
  - WRITE
  - CHECK (only when the checksum is compiled in)
  - DONE
  - ERROR
- A byte transfers on a rising edge where byte_valid_i && byte_ready_o.
- byte_ready_o is high only in LEN_LO, LEN_HI, DATA and CHECK.
- IDLE/DONE/ERROR with start_i=1 → LEN_LO. On that transition:
  - words_loaded_o, the byte index, the running sum and done_o/error_o are cleared.
- start_i in any other state is ignored.
- LEN_LO: the transferred byte becomes count[7:0] → LEN_HI.
- LEN_HI: the transferred byte becomes count[15:8].
  - count==0 or count>MEMORY_DEPTH → ERROR.
  - Otherwise → DATA.
- DATA: bytes fill the word little-endian; byte k of the word goes to bits [8k+7:8k].
  - On the 4th byte → WRITE.
- WRITE lasts exactly one cycle:
  - mem_we_o=1.
  - mem_address_o = BASE_ADDRESS + 4*words_loaded_o (pre-increment value).
  - mem_data_o = the assembled word.
  - words_loaded_o increments at the end of WRITE.
- WRITE exits:
  - More words remain → DATA.
  - Last word, checksum compiled in → CHECK.
  - Last word, checksum compiled out → DONE.
- mem_address_o and mem_data_o hold their last values outside WRITE; mem_we_o is 0 outside WRITE.
- cpu_hold_o is 1 in LEN_LO, LEN_HI, DATA, WRITE, CHECK and ERROR, and 0 in IDLE and DONE.
- done_o is 1 only in DONE; error_o is 1 only in ERROR.
- Address arithmetic is DATA_WIDTH-bit unsigned and wraps modulo 2^DATA_WIDTH; no overflow check.
- Stalls (byte_valid_i low) may be arbitrarily long; there is no timeout.

## Timing
- Reset values:
  - state IDLE.
  - byte_ready_o, mem_we_o, cpu_hold_o, busy_o, done_o, error_o = 0.
  - mem_address_o = BASE_ADDRESS.
  - mem_data_o = 0.
  - words_loaded_o = 0.
- reset asserted mid-session aborts immediately:
  - No further writes occur.
  - Words already written stay in memory.
  - cpu_hold_o drops the cycle after reset is sampled.
- All outputs are registered or decoded from the registered state; there is no combinational path from byte_i/byte_valid_i to any output.
- Latency: the write strobe is asserted in the cycle after the 4th byte of a word is accepted.
- Throughput: at most 4 words per 20 cycles (4 transfer cycles + 1 WRITE per word).
- Session length with a zero-stall stream: 1 (start) + 2 + 5N (+1 with checksum) cycles, from start_i to DONE.
- byte_valid_i asserted during WRITE is not consumed; the source must hold the byte until ready.

## Configuration
- LOADER_CHECKSUM_EN defined:
  - After the last WRITE the block enters CHECK and accepts one byte.
  - That byte must equal the 8-bit modulo-256 sum of all 4N payload bytes; length bytes are excluded.
  - Match → DONE; mismatch → ERROR.
  - Memory already written is not rolled back, and cpu_hold_o stays high in ERROR.
- LOADER_CHECKSUM_EN undefined: the CHECK state and the sum register are absent, and the last WRITE goes directly to DONE.

## Test plan
- Reset check: drive reset=1 for 2 cycles → every output at its reset value; byte_ready_o=0 while start_i=0.
- Single-word load: start, bytes 01 00 13 05 A0 00, no stalls.
  - Exactly one mem_we_o pulse with address 0x00400000 and data 0x00A00513.
  - words_loaded_o=1; done_o=1; cpu_hold_o=0.
- Three-word load with byte_valid_i toggled every other cycle.
  - Writes land at 0x00400000, 0x00400004 and 0x00400008 with the correct little-endian words.
  - byte_ready_o is low in each WRITE cycle.
- Bad length: header 00 00, then separately 21 00 with MEMORY_DEPTH=32.
  - Each goes to ERROR with no mem_we_o and error_o=1.
  - A later start_i recovers to a normal load.
- Abort and ignored start: reset after the 6th payload byte of a 2-word load → exactly 1 write occurred and all outputs return to reset values. start_i pulsed mid-DATA → no effect.
- With LOADER_CHECKSUM_EN, header 01 00:
  - Payload 13 05 A0 00, checksum B8 → DONE.
  - Same payload, checksum B9 → ERROR, cpu_hold_o stays 1, and the word is still written.
